// File: rtl/laundry_collector_ctrl.sv
// Laundry pickup/wash sequencer: visits requested floors top-down, waits for a
// send at each floor (bounded by a timer), then runs a fixed-length wash cycle.
module laundry_collector_ctrl #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 3,
  parameter int WAIT_CYCLES = 10,
  parameter int WASH_CYCLES = 50,
  parameter int TIMER_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_FLOORS-1:0] req_laundry,
  input  logic [NUM_FLOORS-1:0] send,
  output logic [FLOOR_W-1:0]    at_floor,
  output logic                  busy,
  output logic                  wash_done,
  output logic [NUM_FLOORS-1:0] missed
);

  typedef enum logic [1:0] {
    IDLE,
    VISIT,
    WASH,
    DONE
  } state_t;

  state_t                state, state_next;
  logic [NUM_FLOORS-1:0] pending, pending_next;
  logic [NUM_FLOORS-1:0] missed_q, missed_next;
  logic                  loaded, loaded_next;
  logic [TIMER_W-1:0]    timer, timer_next;
  logic [FLOOR_W-1:0]    cur, cur_next;

  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] remaining;
  logic                  send_hit;
  logic                  wait_expired;

  // Floor number (1-based) of the highest set bit in mask, 0 if mask is empty.
  function automatic logic [FLOOR_W-1:0] top_floor(input logic [NUM_FLOORS-1:0] mask);
    logic [FLOOR_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i]) f = FLOOR_W'(i + 1);
    end
    return f;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pending  <= '0;
      missed_q <= '0;
      loaded   <= 1'b0;
      timer    <= '0;
      cur      <= '0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      missed_q <= missed_next;
      loaded   <= loaded_next;
      timer    <= timer_next;
      cur      <= cur_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    missed_next  = missed_q;
    loaded_next  = loaded;
    timer_next   = timer;
    cur_next     = cur;
    cur_mask     = '0;
    send_hit     = 1'b0;
    remaining    = pending;
    wait_expired = (timer == TIMER_W'(WAIT_CYCLES - 1));

    // Decode the current floor into a one-hot mask; only its send bit is observed.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (cur == FLOOR_W'(i + 1)) begin
        cur_mask[i] = 1'b1;
        send_hit    = send[i];
      end
    end

    case (state)
      IDLE: begin
        if (start && (|req_laundry)) begin
          pending_next = req_laundry;
          missed_next  = '0;
          loaded_next  = 1'b0;
          timer_next   = '0;
          cur_next     = top_floor(req_laundry);
          state_next   = VISIT;
        end
      end

      VISIT: begin
        timer_next = timer + 1'b1;
        if (send_hit || wait_expired) begin
          remaining    = pending & ~cur_mask;
          pending_next = remaining;
          timer_next   = '0;
          if (send_hit) loaded_next = 1'b1;
          else          missed_next = missed_q | cur_mask;

          // A send on the last floor counts as a load even though loaded is not yet set.
          if (|remaining)                state_next = VISIT;
          else if (loaded || send_hit)   state_next = WASH;
          else                           state_next = IDLE;
          if (|remaining) cur_next = top_floor(remaining);
        end
      end

      WASH: begin
        if (timer == TIMER_W'(WASH_CYCLES - 1)) begin
          timer_next = '0;
          state_next = DONE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign at_floor  = (state == VISIT) ? cur : '0;
  assign busy      = (state != IDLE);
  assign wash_done = (state == DONE);
  assign missed    = missed_q;

endmodule
